// File: rtl/ahb_matrix_req.sv
// ahb_matrix_req: master-side request stage of the AHB matrix (one per master port).
// Latency: master address phase in cycle T reaches the downstream bus at T+1 at the earliest.
// Backpressure: master stalled via S_HREADYOUT while waiting for grant; data phase mirrors M_HREADY.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   S_*                    AHB-Lite slave interface facing the master
//   ARB_*                  request / grant handshake with the matrix arbiter
//   M_*                    AHB-Lite master interface onto the shared downstream bus
//
// Optional feature: define AHB_MATRIX_REQ_BURST_LOCK_EN to hold ARB_PRIORITY_LOCK
// across a defined-length/incrementing burst until the master starts a SINGLE
// transfer, goes IDLE, or deselects the port.

module ahb_matrix_req #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    // master side
    input  logic              S_HSEL,
    input  logic [1:0]        S_HTRANS,
    input  logic              S_HWRITE,
    input  logic [ADDR_W-1:0] S_HADDR,
    input  logic [2:0]        S_HSIZE,
    input  logic [2:0]        S_HBURST,
    input  logic [3:0]        S_HPROT,
    input  logic              S_HMASTLOCK,
    input  logic [DATA_W-1:0] S_HWDATA,
    input  logic              S_HREADY,
    output logic              S_HREADYOUT,
    output logic              S_HRESP,
    output logic [DATA_W-1:0] S_HRDATA,
    // arbiter handshake
    output logic              ARB_REQ,
    input  logic              ARB_REQ_ACK,
    input  logic              ARB_GRANT,
    output logic              ARB_GRANT_ACK,
    output logic              ARB_PRIORITY_LOCK,
    // downstream bus
    output logic [1:0]        M_HTRANS,
    output logic              M_HWRITE,
    output logic [ADDR_W-1:0] M_HADDR,
    output logic [2:0]        M_HSIZE,
    output logic [2:0]        M_HBURST,
    output logic [3:0]        M_HPROT,
    output logic              M_HMASTLOCK,
    output logic [DATA_W-1:0] M_HWDATA,
    input  logic              M_HREADY,
    input  logic              M_HRESP,
    input  logic [DATA_W-1:0] M_HRDATA
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    state_t state_q, state_d;

    // buffered address phase
    logic [1:0]        htrans_q,    htrans_d;
    logic              hwrite_q,    hwrite_d;
    logic [ADDR_W-1:0] haddr_q,     haddr_d;
    logic [2:0]        hsize_q,     hsize_d;
    logic [2:0]        hburst_q,    hburst_d;
    logic [3:0]        hprot_q,     hprot_d;
    logic              hmastlock_q, hmastlock_d;

    logic accept;
    logic issue;
    logic capture;

    // IDLE/BUSY never qualify: they complete zero-wait OKAY without touching the buffer.
    assign accept = S_HSEL & S_HTRANS[1] & S_HREADY;
    assign issue  = (state_q == ST_WAIT_GNT) & ARB_GRANT & M_HREADY;

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        S_HREADYOUT   = 1'b1;
        S_HRESP       = 1'b0;
        S_HRDATA      = '0;
        ARB_REQ       = 1'b0;
        ARB_GRANT_ACK = 1'b0;
        M_HTRANS      = HTRANS_IDLE;
        M_HWRITE      = 1'b0;
        M_HADDR       = '0;
        M_HSIZE       = '0;
        M_HBURST      = '0;
        M_HPROT       = '0;
        M_HMASTLOCK   = 1'b0;
        M_HWDATA      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    capture = 1'b1;
                    state_d = ST_WAIT_GNT;
                end
            end

            ST_WAIT_GNT: begin
                ARB_REQ     = 1'b1;
                S_HREADYOUT = 1'b0;
                // The address phase only goes out when the shared bus can take it,
                // so the grant is consumed in the same cycle it is used.
                if (issue) begin
                    M_HTRANS      = htrans_q;
                    M_HWRITE      = hwrite_q;
                    M_HADDR       = haddr_q;
                    M_HSIZE       = hsize_q;
                    M_HBURST      = hburst_q;
                    M_HPROT       = hprot_q;
                    M_HMASTLOCK   = hmastlock_q;
                    ARB_GRANT_ACK = 1'b1;
                    state_d       = ST_DATA;
                end
            end

            ST_DATA: begin
                // Data phase is a straight pass-through; the master still holds
                // its write data because it was stalled until now.
                M_HWDATA    = S_HWDATA;
                S_HRDATA    = M_HRDATA;
                S_HREADYOUT = M_HREADY;
                S_HRESP     = M_HRESP;
                if (M_HREADY) begin
                    if (accept) begin
                        capture = 1'b1;
                        state_d = ST_WAIT_GNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address-phase buffer
    // ------------------------------------------------------------------
    always_comb begin
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        haddr_d     = haddr_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        hprot_d     = hprot_q;
        hmastlock_d = hmastlock_q;
        if (capture) begin
            htrans_d    = S_HTRANS;
            hwrite_d    = S_HWRITE;
            haddr_d     = S_HADDR;
            hsize_d     = S_HSIZE;
            hburst_d    = S_HBURST;
            hprot_d     = S_HPROT;
            hmastlock_d = S_HMASTLOCK;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            haddr_q     <= '0;
            hsize_q     <= '0;
            hburst_q    <= '0;
            hprot_q     <= '0;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            haddr_q     <= haddr_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hprot_q     <= hprot_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    // ------------------------------------------------------------------
    // Priority lock towards the arbiter
    // ------------------------------------------------------------------
    logic lock_mastlock;

    // The buffered lock bit is stale once the port has gone idle.
    assign lock_mastlock = (state_q != ST_IDLE) & hmastlock_q;

`ifdef AHB_MATRIX_REQ_BURST_LOCK_EN
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    logic burst_active_q, burst_active_d;
    logic burst_set, burst_clr;

    assign burst_set = ARB_GRANT_ACK & (htrans_q == HTRANS_NONSEQ) & (hburst_q != HBURST_SINGLE);

    // The burst is over once the master starts a SINGLE, goes IDLE, or leaves this port.
    assign burst_clr = S_HREADY & ( ~S_HSEL
                                  | (S_HSEL & (S_HTRANS == HTRANS_IDLE))
                                  | (accept & (S_HTRANS == HTRANS_NONSEQ) & (S_HBURST == HBURST_SINGLE)));

    always_comb begin
        burst_active_d = burst_active_q;
        if (burst_set) begin
            burst_active_d = 1'b1;
        end else if (burst_clr) begin
            burst_active_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            burst_active_q <= 1'b0;
        end else begin
            burst_active_q <= burst_active_d;
        end
    end

    assign ARB_PRIORITY_LOCK = lock_mastlock | burst_active_q;
`else
    assign ARB_PRIORITY_LOCK = lock_mastlock;
`endif

    // The arbiter must acknowledge the request no later than the grant is consumed.
    req_ack_with_grant: assert property (
        @(posedge HCLK) disable iff (!HRESETn) issue |-> ARB_REQ_ACK
    );

endmodule
